multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mcc_pkg.sv | 65 ++++++
 rtl/multicycle_control_opcode_rom.sv | 74 +++++++
 rtl/multicycle_control.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcc_pkg.sv
// mcc_pkg: shared definitions for the multicycle controller.
// Holds opcode values, FSM state encoding, control-word layout and ALU encodings.
package mcc_pkg;

   // Opcode values (5-bit field)
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SW   = 5'b01001;
   localparam logic [4:0] OP_BEQ  = 5'b01100;
   localparam logic [4:0] OP_J    = 5'b10000;
   localparam logic [4:0] OP_JAL  = 5'b10001;
   localparam logic [4:0] OP_TEST = 5'b11000;

   // ALU function encodings
   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_SUB = 2'b01;
   localparam logic [1:0] ALU_OP_TST = 2'b10;

   // ALU operand-2 select encodings
   localparam logic [1:0] SRC2_REG = 2'b00;   // register operand
   localparam logic [1:0] SRC2_IMM = 2'b01;   // immediate (ADDI)
   localparam logic [1:0] SRC2_OFS = 2'b10;   // address offset (LW/SW)

   // Controller states; TRAP only exists when illegal-opcode trapping is built in
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
`ifdef MCC_ILLEGAL_TRAP_EN
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
`else
      S_WB     = 3'd4
`endif
   } state_t;

   // Control word produced by the opcode ROM and registered in DECODE.
   // reg_write here means "instruction needs a WB cycle".
   localparam int CW_W = 14;
   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] alu_src2;
      logic       alu_src1;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       result_src;
      logic       branch;
      logic       jump;
      logic       link;
      logic       test;
   } ctrl_word_t;

   localparam ctrl_word_t CW_NOP = ctrl_word_t'({CW_W{1'b0}});

   // True when the instruction needs a MEM phase
   function automatic logic cw_needs_mem(input ctrl_word_t cw);
      return cw.mem_read | cw.mem_write;
   endfunction

endpackage

// File: rtl/multicycle_control_opcode_rom.sv
// opcode_rom: purely combinational opcode -> control word decode.
// Unknown opcodes yield an all-zero control word and raise o_illegal.
module opcode_rom
   import mcc_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic [OPW-1:0] i_opcode,
   output ctrl_word_t     o_cw,
   output logic           o_illegal
);

   // Decode table; defaults make every unlisted opcode a NOP flagged illegal
   always_comb begin
      o_cw      = CW_NOP;
      o_illegal = 1'b0;
      case (i_opcode)
         OPW'(OP_ADD): begin
            o_cw.alu_op    = ALU_OP_ADD;
            o_cw.alu_src1  = 1'b1;
            o_cw.reg_dst   = 1'b1;
            o_cw.reg_write = 1'b1;
         end
         OPW'(OP_SUB): begin
            o_cw.alu_op    = ALU_OP_SUB;
            o_cw.alu_src1  = 1'b1;
            o_cw.reg_dst   = 1'b1;
            o_cw.reg_write = 1'b1;
         end
         OPW'(OP_ADDI): begin
            o_cw.alu_op    = ALU_OP_ADD;
            o_cw.alu_src2  = SRC2_IMM;
            o_cw.alu_src1  = 1'b1;
            o_cw.reg_write = 1'b1;
         end
         OPW'(OP_LW): begin
            o_cw.alu_op     = ALU_OP_ADD;
            o_cw.alu_src2   = SRC2_OFS;
            o_cw.alu_src1   = 1'b1;
            o_cw.mem_read   = 1'b1;
            o_cw.result_src = 1'b1;
            o_cw.reg_write  = 1'b1;
         end
         OPW'(OP_SW): begin
            o_cw.alu_op    = ALU_OP_ADD;
            o_cw.alu_src2  = SRC2_OFS;
            o_cw.alu_src1  = 1'b1;
            o_cw.mem_write = 1'b1;
         end
         OPW'(OP_BEQ): begin
            o_cw.alu_op   = ALU_OP_SUB;
            o_cw.alu_src1 = 1'b1;
            o_cw.branch   = 1'b1;
         end
         OPW'(OP_J): begin
            o_cw.jump = 1'b1;
         end
         OPW'(OP_JAL): begin
            o_cw.jump      = 1'b1;
            o_cw.link      = 1'b1;
            o_cw.reg_write = 1'b1;
         end
         OPW'(OP_TEST): begin
            o_cw.alu_op   = ALU_OP_TST;
            o_cw.alu_src1 = 1'b1;
            o_cw.test     = 1'b1;
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB controller for a multicycle datapath.
// Outputs are decoded from the state register and the registered control word.
// Build option MCC_ILLEGAL_TRAP_EN: illegal opcodes enter a TRAP state and raise
// 'illegal' until reset; otherwise they execute as a NOP.
module multicycle_control
   import mcc_pkg::*;
#(
   parameter int IW          = 16,
   parameter int OPW         = 5,
   parameter int OP_LSB      = 11,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [IW-1:0] instr,
   input  logic          zero,
   input  logic          mem_ready,
   output logic          reg_write,
   output logic          mem_read,
   output logic          mem_write,
   output logic          reg_dst,
   output logic          result_src,
   output logic          alu_src1,
   output logic          pc_write,
   output logic          jump,
   output logic          branch_taken,
   output logic          link,
   output logic          test,
   output logic [1:0]    alu_op,
   output logic [1:0]    alu_src2,
   output logic          busy,
`ifdef MCC_ILLEGAL_TRAP_EN
   output logic          illegal,
`endif
   output logic          bus_err
);

   localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_ir;
   ctrl_word_t       r_cw;
   ctrl_word_t       w_rom_cw;
   logic             w_rom_illegal;
   logic [OPW-1:0]   w_opcode;
   logic [7:0]       r_wait_cnt;
   logic [7:0]       w_wait_inc;
   logic             w_mem_timeout;
   logic             r_bus_err;
   logic             w_unused_ir;

   assign w_opcode   = r_ir[OP_LSB +: OPW];
   assign w_wait_inc = r_wait_cnt + 8'd1;

   // Operand fields of IR are consumed by the datapath, not by this controller
   assign w_unused_ir = ^r_ir;

   // Timeout fires on the MEM cycle whose missing mem_ready would bring the count
   // to MEM_TIMEOUT; a mem_ready on that same cycle wins as completion.
   assign w_mem_timeout = (r_state == S_MEM) && !mem_ready && (w_wait_inc == C_TIMEOUT);

   assign bus_err = r_bus_err;

   opcode_rom #(
      .OPW(OPW)
   ) u_rom (
      .i_opcode  (w_opcode),
      .o_cw      (w_rom_cw),
      .o_illegal (w_rom_illegal)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Instruction register, loaded on an accepted handshake in FETCH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ir <= {IW{1'b0}};
      end else if ((r_state == S_FETCH) && instr_valid) begin
         r_ir <= instr;
      end
   end

   // Control word, captured from the ROM during DECODE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cw <= CW_NOP;
      end else if (r_state == S_DECODE) begin
         r_cw <= w_rom_cw;
      end
   end

   // MEM wait counter: cleared outside MEM, counts MEM cycles without mem_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= 8'd0;
      end else if (r_state != S_MEM) begin
         r_wait_cnt <= 8'd0;
      end else if (!mem_ready) begin
         r_wait_cnt <= w_wait_inc;
      end
   end

   // Bus-error flag: one-cycle pulse following a memory timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_mem_timeout;
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      w_state_nxt  = r_state;
      instr_ready  = 1'b0;
      busy         = 1'b1;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_dst      = 1'b0;
      result_src   = 1'b0;
      alu_src1     = 1'b0;
      pc_write     = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      link         = 1'b0;
      test         = 1'b0;
      alu_op       = 2'b00;
      alu_src2     = 2'b00;
`ifdef MCC_ILLEGAL_TRAP_EN
      illegal      = 1'b0;
`endif
      case (r_state)
         S_FETCH: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            if (instr_valid) begin
               w_state_nxt = S_DECODE;
            end else begin
               w_state_nxt = S_FETCH;
            end
         end
         S_DECODE: begin
`ifdef MCC_ILLEGAL_TRAP_EN
            if (w_rom_illegal) begin
               w_state_nxt = S_TRAP;
            end else begin
               w_state_nxt = S_EXEC;
            end
`else
            w_state_nxt = S_EXEC;
`endif
         end
         S_EXEC: begin
            alu_op       = r_cw.alu_op;
            alu_src2     = r_cw.alu_src2;
            alu_src1     = r_cw.alu_src1;
            reg_dst      = r_cw.reg_dst;
            test         = r_cw.test;
            jump         = r_cw.jump;
            branch_taken = r_cw.branch & zero;
            pc_write     = r_cw.jump | (r_cw.branch & zero);
            if (cw_needs_mem(r_cw)) begin
               w_state_nxt = S_MEM;
            end else if (r_cw.reg_write) begin
               w_state_nxt = S_WB;
            end else begin
               w_state_nxt = S_FETCH;
            end
         end
         S_MEM: begin
            mem_read  = r_cw.mem_read;
            mem_write = r_cw.mem_write;
            if (mem_ready) begin
               if (r_cw.mem_read) begin
                  w_state_nxt = S_WB;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end else if (w_mem_timeout) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_MEM;
            end
         end
         S_WB: begin
            reg_write   = 1'b1;
            reg_dst     = r_cw.reg_dst;
            result_src  = r_cw.result_src;
            link        = r_cw.link;
            w_state_nxt = S_FETCH;
         end
`ifdef MCC_ILLEGAL_TRAP_EN
         S_TRAP: begin
            illegal     = 1'b1;
            w_state_nxt = S_TRAP;
         end
`endif
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
// (default build, MEM_TIMEOUT=15). Inputs driven and outputs sampled on negedge.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        reg_write, mem_read, mem_write, reg_dst, result_src, alu_src1;
   logic        pc_write, jump, branch_taken, link, test, busy, bus_err;
   logic [1:0]  alu_op, alu_src2;
   logic [14:0] ctl;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign ctl = {reg_write, mem_read, mem_write, reg_dst, result_src, alu_src1,
                 pc_write, jump, branch_taken, link, test, alu_op, alu_src2};

   multicycle_control #(
      .IW(16), .OPW(5), .OP_LSB(11), .MEM_TIMEOUT(15)
   ) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_dst(reg_dst), .result_src(result_src), .alu_src1(alu_src1),
      .pc_write(pc_write), .jump(jump), .branch_taken(branch_taken),
      .link(link), .test(test), .alu_op(alu_op), .alu_src2(alu_src2),
      .busy(busy), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present an instruction in FETCH; returns at the negedge of cycle 1 (DECODE)
   task automatic issue(input logic [15:0] word);
      chk("issue_ready", {15'd0, instr_ready}, 16'd1);
      instr       = word;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b1; instr = 16'hFFFF; zero = 1'b0; mem_ready = 1'b0;
      #7;
      chk("rst_ready", {15'd0, instr_ready}, 16'd1);
      chk("rst_busy",  {15'd0, busy}, 16'd0);
      chk("rst_ctl",   {1'b0, ctl}, 16'd0);
      chk("rst_buserr", {15'd0, bus_err}, 16'd0);
      tick();
      rst = 1'b0; instr_valid = 1'b0;
      tick();
      chk("idle_ready", {15'd0, instr_ready}, 16'd1);
      chk("idle_busy",  {15'd0, busy}, 16'd0);

      // ADD
      issue(16'h0000);
      chk("add_c1_ready", {15'd0, instr_ready}, 16'd0);
      chk("add_c1_busy",  {15'd0, busy}, 16'd1);
      chk("add_c1_rw",    {15'd0, reg_write}, 16'd0);
      tick();
      chk("add_c2_ready", {15'd0, instr_ready}, 16'd0);
      chk("add_c2_rw",    {15'd0, reg_write}, 16'd0);
      chk("add_c2_aluop", {14'd0, alu_op}, 16'd0);
      chk("add_c2_src1",  {15'd0, alu_src1}, 16'd1);
      tick();
      chk("add_c3_ready", {15'd0, instr_ready}, 16'd0);
      chk("add_c3_rw",    {15'd0, reg_write}, 16'd1);
      chk("add_c3_rdst",  {15'd0, reg_dst}, 16'd1);
      chk("add_c3_rsrc",  {15'd0, result_src}, 16'd0);
      tick();
      chk("add_c4_ready", {15'd0, instr_ready}, 16'd1);
      chk("add_c4_rw",    {15'd0, reg_write}, 16'd0);

      // SUB
      issue(16'h0800);
      tick();
      chk("sub_c2_aluop", {14'd0, alu_op}, 16'd1);
      chk("sub_c2_rdst",  {15'd0, reg_dst}, 16'd1);
      tick();
      chk("sub_c3_rw",    {15'd0, reg_write}, 16'd1);
      tick();
      chk("sub_c4_ready", {15'd0, instr_ready}, 16'd1);

      // ADDI
      issue(16'h2800);
      tick();
      chk("addi_c2_src2",  {14'd0, alu_src2}, 16'd1);
      chk("addi_c2_aluop", {14'd0, alu_op}, 16'd0);
      tick();
      chk("addi_c3_rw",    {15'd0, reg_write}, 16'd1);
      chk("addi_c3_rdst",  {15'd0, reg_dst}, 16'd0);
      tick();
      chk("addi_c4_ready", {15'd0, instr_ready}, 16'd1);

      // LW with three wait cycles
      issue(16'h4000);
      tick();
      chk("lw_c2_src2", {14'd0, alu_src2}, 16'd2);
      chk("lw_c2_mrd",  {15'd0, mem_read}, 16'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("lw_mem_rd", {15'd0, mem_read}, 16'd1);
         chk("lw_mem_rw", {15'd0, reg_write}, 16'd0);
         if (i == 3) mem_ready = 1'b1;
         tick();
      end
      mem_ready = 1'b0;
      chk("lw_wb_rw",   {15'd0, reg_write}, 16'd1);
      chk("lw_wb_rsrc", {15'd0, result_src}, 16'd1);
      chk("lw_wb_mrd",  {15'd0, mem_read}, 16'd0);
      tick();
      chk("lw_c8_ready", {15'd0, instr_ready}, 16'd1);

      // SW with memory never ready: timeout after 15 MEM cycles
      issue(16'h4800);
      tick();
      chk("sw_c2_src2", {14'd0, alu_src2}, 16'd2);
      chk("sw_c2_mwr",  {15'd0, mem_write}, 16'd0);
      tick();
      for (int i = 0; i < 15; i++) begin
         chk("swto_mem", {13'd0, mem_write, bus_err, reg_write}, 16'h0004);
         tick();
      end
      chk("swto_buserr", {15'd0, bus_err}, 16'd1);
      chk("swto_mwr",    {15'd0, mem_write}, 16'd0);
      chk("swto_ready",  {15'd0, instr_ready}, 16'd1);
      chk("swto_rw",     {15'd0, reg_write}, 16'd0);
      tick();
      chk("swto_pulse",  {15'd0, bus_err}, 16'd0);
      chk("swto_ready2", {15'd0, instr_ready}, 16'd1);

      // SW with mem_ready arriving on the timeout cycle: completion, no bus_err
      issue(16'h4800);
      tick();
      tick();
      for (int i = 0; i < 14; i++) begin
         chk("swsim_mem", {15'd0, mem_write}, 16'd1);
         tick();
      end
      chk("swsim_last", {15'd0, mem_write}, 16'd1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("swsim_buserr", {15'd0, bus_err}, 16'd0);
      chk("swsim_ready",  {15'd0, instr_ready}, 16'd1);
      tick();
      chk("swsim_buserr2", {15'd0, bus_err}, 16'd0);

      // BEQ taken
      zero = 1'b1;
      issue(16'h6000);
      tick();
      chk("beq1_c2_br",    {13'd0, pc_write, branch_taken, jump}, 16'h0006);
      chk("beq1_c2_aluop", {14'd0, alu_op}, 16'd1);
      tick();
      chk("beq1_c3_ready", {15'd0, instr_ready}, 16'd1);
      chk("beq1_c3_pcw",   {15'd0, pc_write}, 16'd0);

      // BEQ not taken
      zero = 1'b0;
      issue(16'h6000);
      tick();
      chk("beq0_c2_br",    {13'd0, pc_write, branch_taken, jump}, 16'h0000);
      tick();
      chk("beq0_c3_ready", {15'd0, instr_ready}, 16'd1);

      // J
      issue(16'h8000);
      tick();
      chk("j_c2", {12'd0, pc_write, jump, branch_taken, link}, 16'h000C);
      tick();
      chk("j_c3_ready", {15'd0, instr_ready}, 16'd1);
      chk("j_c3_rw",    {15'd0, reg_write}, 16'd0);

      // JAL
      issue(16'h8800);
      tick();
      chk("jal_c2", {12'd0, pc_write, jump, link, reg_write}, 16'h000C);
      tick();
      chk("jal_c3", {12'd0, reg_write, link, jump, pc_write}, 16'h000C);
      chk("jal_c3_ready", {15'd0, instr_ready}, 16'd0);
      tick();
      chk("jal_c4_ready", {15'd0, instr_ready}, 16'd1);

      // TEST
      issue(16'hC000);
      tick();
      chk("test_c2",       {15'd0, test}, 16'd1);
      chk("test_c2_aluop", {14'd0, alu_op}, 16'd2);
      tick();
      chk("test_c3_ready", {15'd0, instr_ready}, 16'd1);
      chk("test_c3_test",  {15'd0, test}, 16'd0);

      // Illegal opcode 11111 executes as NOP
      issue(16'hF800);
      tick();
      chk("ill_c2_ctl",  {1'b0, ctl}, 16'd0);
      chk("ill_c2_busy", {15'd0, busy}, 16'd1);
      tick();
      chk("ill_c3_ready", {15'd0, instr_ready}, 16'd1);
      chk("ill_c3_ctl",   {1'b0, ctl}, 16'd0);

      // Reset asserted during MEM of SW
      issue(16'h4800);
      tick();
      tick();
      chk("rstmem_mwr", {15'd0, mem_write}, 16'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstmem_mwr0",  {15'd0, mem_write}, 16'd0);
      chk("rstmem_ready", {15'd0, instr_ready}, 16'd1);
      chk("rstmem_busy",  {15'd0, busy}, 16'd0);
      tick();
      rst = 1'b0;
      chk("rstmem_ctl", {1'b0, ctl}, 16'd0);
      tick();
      chk("rstmem_idle", {15'd0, instr_ready}, 16'd1);
      chk("rstmem_berr", {15'd0, bus_err}, 16'd0);

      // ADD after reset recovery
      issue(16'h0000);
      tick();
      tick();
      chk("add2_c3_rw", {15'd0, reg_write}, 16'd1);
      tick();
      chk("add2_c4_ready", {15'd0, instr_ready}, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
